// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle of the UART receiver: serial line in, byte/strobes/status out.
// master = the receiver itself, slave = the line driver / downstream consumer.
interface uart_receiver_if;
  logic       UART_RX;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_ERR;
  logic       RX_STATUS;

  modport master (
    input  UART_RX,
    output RX_DATA,
    output RX_VALID,
    output RX_ERR,
    output RX_STATUS
  );

  modport slave (
    output UART_RX,
    input  RX_DATA,
    input  RX_VALID,
    input  RX_ERR,
    input  RX_STATUS
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop synchroniser, mid-bit sampling of start/8 data/stop bits.
// Optional even-parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | qualifying the start bit at its midpoint
// DATA      | sampling the 8 data bits mid-bit
// PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit, issuing RX_VALID or RX_ERR
// WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  uart_receiver_if.master  rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  logic          sync1_q;
  logic          rx_s_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          err_q;
  logic          frame_ok;
  logic          cnt_half;
  logic          cnt_last;

`ifdef UART_RX_PARITY_EN
  logic          par_ok_q;
  assign frame_ok = par_ok_q;
`else
  assign frame_ok = 1'b1;
`endif

  assign cnt_half = (cnt_q == CW'(H - 1));
  assign cnt_last = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // After 8 shifts the first received bit lands in bit 7 (MSB first) or bit 0 (LSB first).
  always_comb begin
    shift_d = shift_q;
    if (MSB_FIRST) shift_d = {shift_q[6:0], rx_s_q};
    else           shift_d = {rx_s_q, shift_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q <= 1'b1;
`endif
    end else begin
      sync1_q <= rx_if.UART_RX;
      rx_s_q  <= sync1_q;
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end

        START: begin
          if (cnt_half) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= AFTER_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_last) begin
            cnt_q    <= '0;
            par_ok_q <= ~(^shift_q ^ rx_s_q);
            state_q  <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif

        // Leaving at mid stop bit leaves half a bit of margin for the next start edge.
        STOP: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
              if (frame_ok) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        WAIT_HIGH: begin
          if (rx_s_q) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_if.RX_DATA   = data_q;
  assign rx_if.RX_VALID  = valid_q;
  assign rx_if.RX_ERR    = err_q;
  assign rx_if.RX_STATUS = (state_q == IDLE);

`ifndef SYNTHESIS
  a_valid_err_excl: assert property (@(posedge clk) !(valid_q && err_q));
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: MSB-first and LSB-first instances, directed table,
// hand-written corner sequences and random frames checked against an event-level model.
module tb_uart_receiver;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + H + 10 * C;
`else
  localparam int LAT = 2 + H + 9 * C;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       err;
    logic       both;
  } ev_t;

  typedef struct {
    bit         inst;
    logic [7:0] data;
    bit         stop;
    int         stop_len;
    bit         par_flip;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  ev_t  exp_a[$];
  ev_t  exp_b[$];
  ev_t  obs_a[$];
  ev_t  obs_b[$];

  logic [7:0] last_a;
  logic [7:0] last_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver_if ifa ();
  uart_receiver_if ifb ();

  uart_receiver #(.CLKS_PER_BIT(C), .MSB_FIRST(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .rx_if (ifa.master)
  );

  uart_receiver #(.CLKS_PER_BIT(C), .MSB_FIRST(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .rx_if (ifb.master)
  );

  always @(negedge clk) begin
    if (ifa.RX_VALID || ifa.RX_ERR)
      obs_a.push_back('{cyc, ifa.RX_DATA, ifa.RX_ERR, ifa.RX_VALID && ifa.RX_ERR});
    if (ifb.RX_VALID || ifb.RX_ERR)
      obs_b.push_back('{cyc, ifb.RX_DATA, ifb.RX_ERR, ifb.RX_VALID && ifb.RX_ERR});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_line(input bit inst, input logic v);
    if (inst) ifb.UART_RX = v;
    else      ifa.UART_RX = v;
  endtask

  // Caller is #1 after a rising edge; returns #1 after the n-th following edge.
  task automatic hold(input bit inst, input logic v, input int n);
    set_line(inst, v);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic send_frame(input bit inst, input logic [7:0] d, input bit stop,
                            input int stop_len, input bit par_flip, output int e0);
    e0 = cyc + 1;
    hold(inst, 1'b0, C);
    for (int i = 0; i < 8; i++) hold(inst, inst ? d[i] : d[7-i], C);
`ifdef UART_RX_PARITY_EN
    hold(inst, (^d) ^ par_flip, C);
`else
    if (par_flip) $display("note: parity flip requested but no parity bit in this build");
`endif
    hold(inst, stop, C * stop_len);
    set_line(inst, 1'b1);
  endtask

  task automatic expect_ev(input bit inst, input int e0, input logic [7:0] d, input logic err);
    if (inst) exp_b.push_back('{e0 + LAT, d, err, 1'b0});
    else      exp_a.push_back('{e0 + LAT, d, err, 1'b0});
  endtask

  task automatic cmp_one(input string name, input ev_t o, input ev_t e);
    chk({name, "_cyc"},  o.cyc,  e.cyc);
    chk({name, "_data"}, o.data, e.data);
    chk({name, "_err"},  o.err,  e.err);
    chk({name, "_excl"}, o.both, 1'b0);
  endtask

  task automatic cmp_queues(input string tag);
    int n;
    chk({tag, "_a_count"}, obs_a.size(), exp_a.size());
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) cmp_one($sformatf("%s_a%0d", tag, i), obs_a[i], exp_a[i]);
    chk({tag, "_b_count"}, obs_b.size(), exp_b.size());
    n = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
    for (int i = 0; i < n; i++) cmp_one($sformatf("%s_b%0d", tag, i), obs_b[i], exp_b[i]);
    obs_a.delete(); exp_a.delete(); obs_b.delete(); exp_b.delete();
  endtask

  initial begin
    vec_t tbl[7];
    int   n_vec;
    int   e0;
    int   k;
    bit   inst;
    logic [7:0] d;
    bit   stop;
    int   len;
    int   gap;

    ifa.UART_RX = 1'b1;
    ifb.UART_RX = 1'b1;

    tbl[0] = '{1'b0, 8'hA5, 1'b1, 1, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 8'hFF, 1'b1, 1, 1'b0, 1'b0, 8'hFF};
    tbl[3] = '{1'b0, 8'h81, 1'b1, 1, 1'b0, 1'b0, 8'h81};
    tbl[4] = '{1'b1, 8'h01, 1'b1, 1, 1'b0, 1'b0, 8'h01};
    tbl[5] = '{1'b0, 8'h07, 1'b1, 1, 1'b0, 1'b0, 8'h07};
    tbl[6] = '{1'b0, 8'h07, 1'b1, 1, 1'b1, 1'b1, 8'h07};
`ifdef UART_RX_PARITY_EN
    n_vec = 7;
`else
    n_vec = 5;
`endif

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_a_data",   ifa.RX_DATA,   8'h00);
    chk("rst_a_valid",  ifa.RX_VALID,  1'b0);
    chk("rst_a_err",    ifa.RX_ERR,    1'b0);
    chk("rst_a_status", ifa.RX_STATUS, 1'b1);
    chk("rst_b_data",   ifb.RX_DATA,   8'h00);
    chk("rst_b_valid",  ifb.RX_VALID,  1'b0);
    chk("rst_b_err",    ifb.RX_ERR,    1'b0);
    chk("rst_b_status", ifb.RX_STATUS, 1'b1);
    last_a = 8'h00;
    last_b = 8'h00;
    @(posedge clk);
    #1;

    // Directed table; consecutive frames on one line are back to back (single stop bit).
    for (int i = 0; i < n_vec; i++) begin
      send_frame(tbl[i].inst, tbl[i].data, tbl[i].stop, tbl[i].stop_len, tbl[i].par_flip, e0);
      expect_ev(tbl[i].inst, e0, tbl[i].exp_data, tbl[i].exp_err);
      if (!tbl[i].exp_err) begin
        if (tbl[i].inst) last_b = tbl[i].exp_data;
        else             last_a = tbl[i].exp_data;
      end
    end
    hold(1'b0, 1'b1, 4);
    chk("tbl_a_status", ifa.RX_STATUS, 1'b1);
    cmp_queues("table");

    // Short low pulse: rejected at the start-bit midpoint.
    e0 = cyc + 1;
    hold(1'b0, 1'b0, 4);
    set_line(1'b0, 1'b1);
    wait_neg(e0 + 3);
    chk("glitch_busy", ifa.RX_STATUS, 1'b0);
    wait_neg(e0 + 9);
    chk("glitch_busy_late", ifa.RX_STATUS, 1'b0);
    wait_neg(e0 + 10);
    chk("glitch_idle", ifa.RX_STATUS, 1'b1);
    chk("glitch_data", ifa.RX_DATA, last_a);
    @(posedge clk);
    #1;
    hold(1'b0, 1'b1, 20);
    cmp_queues("glitch");

    // Framing error followed by a held-low line.
    send_frame(1'b0, 8'hA5, 1'b1, 1, 1'b0, e0);
    expect_ev(1'b0, e0, 8'hA5, 1'b0);
    last_a = 8'hA5;
    send_frame(1'b0, 8'h3C, 1'b0, 3, 1'b0, e0);
    expect_ev(1'b0, e0, 8'hA5, 1'b1);
    k = cyc;
    wait_neg(k);
    chk("brk_busy0", ifa.RX_STATUS, 1'b0);
    wait_neg(k + 2);
    chk("brk_busy2", ifa.RX_STATUS, 1'b0);
    wait_neg(k + 3);
    chk("brk_idle3", ifa.RX_STATUS, 1'b1);
    chk("brk_data", ifa.RX_DATA, 8'hA5);
    @(posedge clk);
    #1;
    cmp_queues("break");

    // Reset in the middle of data bit 4.
    e0 = cyc + 1;
    hold(1'b0, 1'b0, C);
    d = 8'hC3;
    for (int i = 0; i < 4; i++) hold(1'b0, d[7-i], C);
    hold(1'b0, d[3], H);
    reset = 1'b1;
    set_line(1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_a_data",   ifa.RX_DATA,   8'h00);
    chk("abort_b_data",   ifb.RX_DATA,   8'h00);
    chk("abort_a_status", ifa.RX_STATUS, 1'b1);
    last_a = 8'h00;
    last_b = 8'h00;
    @(posedge clk);
    #1;
    hold(1'b0, 1'b1, 3);
    send_frame(1'b0, 8'h5A, 1'b1, 1, 1'b0, e0);
    expect_ev(1'b0, e0, 8'h5A, 1'b0);
    last_a = 8'h5A;
    hold(1'b0, 1'b1, 4);
    cmp_queues("abort");

    // Random frames against the event model.
    for (int i = 0; i < 30; i++) begin
      inst = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      len  = stop ? 1 : int'($urandom_range(1, 3));
      send_frame(inst, d, stop, len, 1'b0, e0);
      if (stop) begin
        expect_ev(inst, e0, d, 1'b0);
        if (inst) last_b = d;
        else      last_a = d;
      end else begin
        expect_ev(inst, e0, inst ? last_b : last_a, 1'b1);
      end
      gap = stop ? int'($urandom_range(0, 5)) : int'($urandom_range(4, 9));
      hold(inst, 1'b1, gap);
    end
    hold(1'b0, 1'b1, 8);
    chk("rnd_a_data", ifa.RX_DATA, last_a);
    chk("rnd_b_data", ifb.RX_DATA, last_b);
    cmp_queues("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
